time_tmr_vote_end: RTL and testbench

Downstream companion of the time-redundancy start stage. It consumes the stream of up-to-three temporally replicated elements tagged with a group ID, reassembles each group, and emits one bitwise-majority-voted element per group. It flags any disagreement or broken group on a fault pulse. With redundancy disabled it acts as a one-deep registered pass-through, so the start/end pair brackets an unprotected pipeline.

---
 rtl/time_tmr_vote_end.sv | 151 +++++++++++++++
 tb/tb_time_tmr_vote_end.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_tmr_vote_end.sv
// Reassembles temporally replicated elements into groups and emits one bitwise-majority
// element per group, with a registered fault pulse on mismatches or broken groups.
//
// state | meaning
// EMPTY | no replica of the current group buffered
// ONE   | e0 holds the first replica of a group
// TWO   | e1/e0 hold the first two replicas of a group
module time_tmr_vote_end #(
    parameter type         DataType = logic,
    parameter int unsigned IDSize   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  DataType           data_i,
    input  logic [IDSize-1:0] id_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic [IDSize-1:0] id_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              fault_o
);

    localparam int unsigned W = $bits(DataType);
    typedef logic [W-1:0] word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    word_t             e0_data, e0_data_nxt;
    word_t             e1_data, e1_data_nxt;
    logic [IDSize-1:0] e0_id, e0_id_nxt;
    logic [IDSize-1:0] e1_id, e1_id_nxt;
    word_t             out_data, out_data_nxt;
    logic [IDSize-1:0] out_id, out_id_nxt;
    logic              out_valid, out_valid_nxt;
    logic              fault, fault_nxt;

    word_t in_data;
    word_t vote;
    logic  accept;
    logic  id_match;
    logic  disagree;

    assign in_data  = word_t'(data_i);
    assign ready_o  = !out_valid || ready_i;
    assign accept   = valid_i && ready_o;
    assign id_match = (id_i == e0_id);
    assign vote     = (e1_data & e0_data) | (e1_data & in_data) | (e0_data & in_data);
    assign disagree = (e1_data != e0_data) || (e0_data != in_data) || (e1_data != in_data);

    assign data_o  = DataType'(out_data);
    assign id_o    = out_id;
    assign valid_o = out_valid;
    assign fault_o = fault;

    always_comb begin
        state_nxt     = state;
        e0_data_nxt   = e0_data;
        e0_id_nxt     = e0_id;
        e1_data_nxt   = e1_data;
        e1_id_nxt     = e1_id;
        out_data_nxt  = out_data;
        out_id_nxt    = out_id;
        out_valid_nxt = out_valid && !ready_i;
        fault_nxt     = 1'b0;

        if (accept) begin
            if (!enable_i) begin
                // Unprotected mode: partial groups are abandoned without a fault.
                out_valid_nxt = 1'b1;
                out_data_nxt  = in_data;
                out_id_nxt    = id_i;
                state_nxt     = EMPTY;
            end else begin
                unique case (state)
                    EMPTY: begin
                        e0_data_nxt = in_data;
                        e0_id_nxt   = id_i;
                        state_nxt   = ONE;
                    end
                    ONE: begin
                        e0_data_nxt = in_data;
                        e0_id_nxt   = id_i;
                        if (id_match) begin
                            e1_data_nxt = e0_data;
                            e1_id_nxt   = e0_id;
                            state_nxt   = TWO;
                        end else begin
                            fault_nxt = 1'b1;
                        end
                    end
                    TWO: begin
                        if (id_match) begin
                            out_valid_nxt = 1'b1;
                            out_data_nxt  = vote;
                            out_id_nxt    = id_i;
                            fault_nxt     = disagree;
                            state_nxt     = EMPTY;
                        end else begin
                            // Broken group: salvage it only if both held replicas agree.
                            fault_nxt = 1'b1;
                            if (e0_data == e1_data) begin
                                out_valid_nxt = 1'b1;
                                out_data_nxt  = e0_data;
                                out_id_nxt    = e0_id;
                            end
                            e0_data_nxt = in_data;
                            e0_id_nxt   = id_i;
                            state_nxt   = ONE;
                        end
                    end
                    default: begin
                        state_nxt = EMPTY;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= EMPTY;
            e0_data   <= '0;
            e0_id     <= '0;
            e1_data   <= '0;
            e1_id     <= '0;
            out_data  <= '0;
            out_id    <= '0;
            out_valid <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            e0_data   <= e0_data_nxt;
            e0_id     <= e0_id_nxt;
            e1_data   <= e1_data_nxt;
            e1_id     <= e1_id_nxt;
            out_data  <= out_data_nxt;
            out_id    <= out_id_nxt;
            out_valid <= out_valid_nxt;
            fault     <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_time_tmr_vote_end.sv
// Scoreboard bench for time_tmr_vote_end: a reference model pushes expected groups on accept,
// outputs are compared against the queue head while presented and popped on handshake.
module tb_time_tmr_vote_end;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic [7:0] data_i;
    logic [0:0] id_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic [0:0] id_o;
    logic       valid_o;
    logic       ready_i;
    logic       fault_o;

    always #5 clk_i = ~clk_i;

    time_tmr_vote_end #(
        .DataType (logic [7:0]),
        .IDSize   (1)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .data_i   (data_i),
        .id_i     (id_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .id_o     (id_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .fault_o  (fault_o)
    );

    typedef enum logic [1:0] {M_EMPTY, M_ONE, M_TWO} mst_t;

    mst_t       mst;
    logic [7:0] m_e0d, m_e1d;
    logic       m_e0i, m_e1i;
    logic       m_valid;
    logic       m_fault;
    logic [8:0] sb_q[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mst     = M_EMPTY;
        m_e0d   = '0;
        m_e1d   = '0;
        m_e0i   = '0;
        m_e1i   = '0;
        m_valid = 1'b0;
        m_fault = 1'b0;
        sb_q.delete();
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input bit acc, input bit en, input logic [7:0] d,
                              input logic id, input bit r);
        bit         emit = 0;
        logic [7:0] ed   = '0;
        logic       ei   = '0;
        bit         f    = 0;
        if (m_valid && r && sb_q.size() > 0) void'(sb_q.pop_front());
        if (acc) begin
            if (!en) begin
                emit = 1; ed = d; ei = id; mst = M_EMPTY;
            end else begin
                case (mst)
                    M_EMPTY: begin m_e0d = d; m_e0i = id; mst = M_ONE; end
                    M_ONE: begin
                        if (id == m_e0i) begin
                            m_e1d = m_e0d; m_e1i = m_e0i; mst = M_TWO;
                        end else begin
                            f = 1;
                        end
                        m_e0d = d; m_e0i = id;
                    end
                    default: begin
                        if (id == m_e0i) begin
                            emit = 1;
                            ed   = (m_e1d & m_e0d) | (m_e1d & d) | (m_e0d & d);
                            ei   = id;
                            f    = (m_e1d != m_e0d) || (m_e0d != d) || (m_e1d != d);
                            mst  = M_EMPTY;
                        end else begin
                            f = 1;
                            if (m_e0d == m_e1d) begin emit = 1; ed = m_e0d; ei = m_e0i; end
                            m_e0d = d; m_e0i = id; mst = M_ONE;
                        end
                    end
                endcase
            end
        end
        m_fault = f;
        if (emit) begin
            sb_q.push_back({ed, ei});
            m_valid = 1'b1;
        end else begin
            m_valid = m_valid && !r;
        end
    endtask

    task automatic check_outputs();
        chk("fault", fault_o, m_fault);
        chk("valid", valid_o, m_valid);
        if (m_valid) begin
            chk("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                chk("data", data_o, sb_q[0][8:1]);
                chk("id", id_o, sb_q[0][0]);
            end
        end
    endtask

    task automatic step(input bit v, input bit en, input logic [7:0] d,
                        input logic id, input bit r);
        @(posedge clk_i); #1;
        check_outputs();
        valid_i  = v;
        enable_i = en;
        data_i   = d;
        id_i     = id;
        ready_i  = r;
        #1;
        chk("ready", ready_o, !m_valid || r);
        model_step(v && (!m_valid || r), en, d, id, r);
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        check_outputs();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_reset();
        chk("rst_valid", valid_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_id", id_o, 0);
        chk("rst_ready", ready_o, 1);
        model_step(0, 0, 8'h00, 1'b0, 1);
    endtask

    task automatic group(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic id);
        step(1, 1, a, id, 1);
        step(1, 1, b, id, 1);
        step(1, 1, c, id, 1);
    endtask

    initial begin
        rst_i    = 1'b1;
        enable_i = 1'b0;
        data_i   = '0;
        id_i     = '0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("init_valid", valid_o, 0);
        chk("init_ready", ready_o, 1);
        model_step(0, 0, 8'h00, 1'b0, 1);

        // clean group
        group(8'hA5, 8'hA5, 8'hA5, 1'b1);
        step(0, 1, 8'h00, 1'b0, 1);
        step(0, 1, 8'h00, 1'b0, 1);

        // single upset
        group(8'hA5, 8'hA4, 8'hA5, 1'b0);
        step(0, 1, 8'h00, 1'b0, 1);
        step(0, 1, 8'h00, 1'b0, 1);

        // broken group
        step(1, 1, 8'h11, 1'b0, 1);
        step(1, 1, 8'h11, 1'b0, 1);
        group(8'h22, 8'h22, 8'h22, 1'b1);
        step(1, 1, 8'h22, 1'b1, 1);
        step(0, 1, 8'h00, 1'b0, 1);
        step(0, 1, 8'h00, 1'b0, 1);
        do_reset();

        // back-pressure
        group(8'h5A, 8'h5A, 8'h5A, 1'b1);
        for (int i = 0; i < 5; i++) step(1, 1, 8'h77, 1'b0, 0);
        step(1, 1, 8'h77, 1'b0, 1);
        step(1, 1, 8'h77, 1'b0, 1);
        step(1, 1, 8'h77, 1'b0, 1);
        step(0, 1, 8'h00, 1'b0, 1);
        step(0, 1, 8'h00, 1'b0, 1);

        // pass-through
        step(1, 0, 8'h01, 1'b1, 1);
        step(1, 0, 8'h02, 1'b0, 1);
        step(1, 0, 8'h03, 1'b1, 1);
        step(0, 0, 8'h00, 1'b0, 1);
        step(0, 0, 8'h00, 1'b0, 1);

        // reset mid-group
        step(1, 1, 8'h3C, 1'b0, 1);
        step(1, 1, 8'h3C, 1'b0, 1);
        do_reset();
        group(8'hC3, 8'hC3, 8'hC3, 1'b1);
        step(0, 1, 8'h00, 1'b0, 1);
        step(0, 1, 8'h00, 1'b0, 1);

        // random mix of groups, upsets, broken groups, mode switches and stalls
        begin
            logic [7:0] base = 8'h00;
            logic       gid  = 1'b0;
            bit         en   = 1'b1;
            for (int i = 0; i < 400; i++) begin
                logic [7:0] d;
                logic       id;
                if ($urandom_range(0, 5) == 0) begin
                    base = 8'($urandom);
                    gid  = ~gid;
                end
                if ($urandom_range(0, 30) == 0) en = ~en;
                d  = base;
                if ($urandom_range(0, 7) == 0) d = d ^ (8'h01 << $urandom_range(0, 7));
                id = gid;
                step($urandom_range(0, 4) != 0, en, d, id, $urandom_range(0, 3) != 0);
            end
        end
        step(0, 1, 8'h00, 1'b0, 1);
        step(0, 1, 8'h00, 1'b0, 1);
        @(posedge clk_i); #1;
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
